// File: rtl/tiny_dnn_pkg.sv
// Shared types and default widths for the tiny_dnn output write-back path.
//   oc_state_t : write-back sequencer state
//   CH_W/SP_W/AD_W : default channel / spatial / address widths
//   LC_W : width of the kernel-finish latency counter
package tiny_dnn_pkg;

  localparam int unsigned CH_W = 4;
  localparam int unsigned SP_W = 10;
  localparam int unsigned AD_W = 12;
  localparam int unsigned LC_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } oc_state_t;

endpackage

// File: rtl/out_ctrl_p_loop1.sv
// Generic wrapping loop counter.
//   init  : force count to 0 (wins over next)
//   next  : advance; wraps to 0 when the count equals last
//   last  : final count value of the loop
//   cnt   : current count (registered)
//   fin_c : count is at last (combinational)
module loop1 #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         next,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         fin_c
);

  assign fin_c = (cnt == last);

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (init) begin
      cnt <= '0;
    end else if (next) begin
      cnt <= fin_c ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/out_ctrl_p.sv
// Output write-back sequencer: after each kernel finish it waits LAT cycles,
// then emits one (ra, oa) beat per output channel under ready/valid.
//   clk, rst_n       : clock, async active-low reset
//   s_init           : new sample, position returns to 0
//   k_fin            : accumulators hold results for the current position
//   od, os, mode     : last channel, positions per channel, address layout
//   out_ready        : downstream accepts the current beat
//   outr, ra, oa     : beat valid, accumulator channel, buffer address
//   out_busy         : accumulators not yet free for the next kernel pass
//   done             : pulse after the last position of a sample is written
//   err              : sticky, a k_fin was lost
module out_ctrl_p
  import tiny_dnn_pkg::*;
#(
  parameter int unsigned CW        = CH_W,
  parameter int unsigned SW        = SP_W,
  parameter int unsigned AW        = AD_W,
  parameter int unsigned LAT       = 2,
  parameter int unsigned BUSY_LEAD = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_init,
  input  logic          k_fin,
  input  logic [CW-1:0] od,
  input  logic [SW-1:0] os,
  input  logic          mode,
  input  logic          out_ready,
  output logic          outr,
  output logic [CW-1:0] ra,
  output logic [AW-1:0] oa,
  output logic          out_busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned PW = CW + SW;
  localparam logic [LC_W-1:0] LC_INIT = LC_W'(LAT - 1);

  oc_state_t       state, state_n;
  logic [LC_W-1:0] lc, lc_n;
  logic            pend, pend_n;
  logic            sinit_d, sinit_n;
  logic            err_n, busy_n, done_n, outr_n;

  logic [CW-1:0]   ct;
  logic [SW-1:0]   wi;
  logic            ct_fin, wi_fin;
  logic            beat, drain_end, wi_init;
  logic [CW+1:0]   lead_sum;
  logic [CW:0]     nch;
  logic [PW-1:0]   prod, addr;

  assign beat      = (state == DRAIN) & out_ready;
  assign drain_end = beat & ct_fin;

  // Position resets on s_init in IDLE, or at end of drain (immediate or deferred s_init)
  assign wi_init = ((state == IDLE) & s_init) | (drain_end & (s_init | sinit_d));

  // Channel counter: held at 0 outside DRAIN, wraps after od
  loop1 #(.W(CW)) u_ct (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (state != DRAIN),
    .next  (beat),
    .last  (od),
    .cnt   (ct),
    .fin_c (ct_fin)
  );

  // Position counter: advances once per completed drain, wraps after os-1
  loop1 #(.W(SW)) u_wi (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (wi_init),
    .next  (drain_end),
    .last  (SW'(os - SW'(1))),
    .cnt   (wi),
    .fin_c (wi_fin)
  );

  assign lead_sum = {2'b00, ct} + (CW+2)'(BUSY_LEAD);

  // Next-state and registered-output logic
  always_comb begin
    state_n = state;
    lc_n    = lc;
    pend_n  = pend;
    sinit_n = sinit_d;
    err_n   = err;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (k_fin) begin
          state_n = WAIT;
          lc_n    = LC_INIT;
        end
      end
      WAIT: begin
        if (lc == '0) begin
          state_n = DRAIN;
        end else begin
          lc_n = lc - LC_W'(1);
        end
      end
      DRAIN: begin
        if (drain_end) begin
          done_n = wi_fin;
          if (pend || k_fin) begin
            state_n = WAIT;
            lc_n    = LC_INIT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // k_fin / s_init arriving while a pass is in flight
    if (state != IDLE) begin
      if (s_init) sinit_n = 1'b1;
      if (k_fin) begin
        if (pend) err_n = 1'b1;
        else      pend_n = 1'b1;
      end
    end

    // End of drain consumes the pending finish (or a same-cycle k_fin) and deferred init
    if (drain_end) begin
      pend_n  = 1'b0;
      sinit_n = 1'b0;
    end

    busy_n = k_fin | pend | (state == WAIT) |
             ((state == DRAIN) & (lead_sum < {2'b00, od}));
    outr_n = (state_n == DRAIN);
  end

  // State and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lc       <= '0;
      pend     <= 1'b0;
      sinit_d  <= 1'b0;
      err      <= 1'b0;
      done     <= 1'b0;
      out_busy <= 1'b0;
      outr     <= 1'b0;
    end else begin
      state    <= state_n;
      lc       <= lc_n;
      pend     <= pend_n;
      sinit_d  <= sinit_n;
      err      <= err_n;
      done     <= done_n;
      out_busy <= busy_n;
      outr     <= outr_n;
    end
  end

  // Address generation: channel-major or position-major layout
  always_comb begin
    nch = {1'b0, od} + (CW+1)'(1);
    if (mode) begin
      prod = PW'(wi) * PW'(nch);
      addr = prod + PW'(ct);
    end else begin
      prod = PW'(ct) * PW'(os);
      addr = prod + PW'(wi);
    end
  end

  assign ra = ct;
  assign oa = AW'(addr);

endmodule

// File: tb/tb_out_ctrl_p.sv
// Self-checking bench for out_ctrl_p: directed scenarios plus randomized
// passes checked against a transaction-level model of the write-back sequence.
module tb_out_ctrl_p;

  localparam int unsigned CW  = 4;
  localparam int unsigned SW  = 10;
  localparam int unsigned AW  = 12;
  localparam int unsigned LAT = 2;
  localparam int unsigned BL  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_init = 1'b0;
  logic          k_fin = 1'b0;
  logic [CW-1:0] od = '0;
  logic [SW-1:0] os = SW'(1);
  logic          mode = 1'b0;
  logic          out_ready = 1'b0;
  logic          outr, out_busy, done, err;
  logic [CW-1:0] ra;
  logic [AW-1:0] oa;

  int vec = 0;
  int bad = 0;
  int mwi = 0;   // model: current position within the sample

  always #5 clk = ~clk;

  out_ctrl_p #(.CW(CW), .SW(SW), .AW(AW), .LAT(LAT), .BUSY_LEAD(BL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_init    (s_init),
    .k_fin     (k_fin),
    .od        (od),
    .os        (os),
    .mode      (mode),
    .out_ready (out_ready),
    .outr      (outr),
    .ra        (ra),
    .oa        (oa),
    .out_busy  (out_busy),
    .done      (done),
    .err       (err)
  );

  // Expected buffer address for channel c at position w under the current layout
  function automatic logic [AW-1:0] exp_oa(int c, int w);
    int a;
    if (mode) a = w * (int'(od) + 1) + c;
    else      a = c * int'(os) + w;
    return AW'(a % (1 << AW));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    vec++; if (outr !== 1'b0)     begin bad++; $display("FAIL reset_outr got=%0b want=0", outr); end
    vec++; if (out_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", out_busy); end
    vec++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    vec++; if (err !== 1'b0)      begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
    vec++; if (ra !== '0)         begin bad++; $display("FAIL reset_ra got=%0d want=0", ra); end
    vec++; if (oa !== '0)         begin bad++; $display("FAIL reset_oa got=%0d want=0", oa); end
    rst_n = 1'b1;
    cyc();
    vec++; if (outr !== 1'b0)     begin bad++; $display("FAIL post_reset_outr got=%0b want=0", outr); end
    mwi = 0;
  endtask

  task automatic test_channel_major();
    logic eo;
    od = 4'd3; os = SW'(2); mode = 1'b0; out_ready = 1'b1;
    s_init = 1'b1; cyc(); s_init = 1'b0; mwi = 0; cyc();
    for (int p = 0; p < 2; p++) begin
      k_fin = 1'b1; cyc(); k_fin = 1'b0;
      for (int i = 1; i <= 8; i++) begin
        eo = (i >= 3 && i <= 6);
        vec++; if (outr !== eo) begin bad++; $display("FAIL cm_outr p=%0d i=%0d got=%0b want=%0b", p, i, outr, eo); end
        if (eo) begin
          vec++;
          if (ra !== CW'(i-3) || oa !== exp_oa(i-3, p)) begin
            bad++; $display("FAIL cm_addr p=%0d i=%0d got ra=%0d oa=%0d want ra=%0d oa=%0d", p, i, ra, oa, i-3, exp_oa(i-3, p));
          end
        end
        vec++; if (out_busy !== (i <= 3)) begin bad++; $display("FAIL cm_busy p=%0d i=%0d got=%0b want=%0b", p, i, out_busy, (i <= 3)); end
        vec++; if (done !== (p == 1 && i == 7)) begin bad++; $display("FAIL cm_done p=%0d i=%0d got=%0b want=%0b", p, i, done, (p == 1 && i == 7)); end
        cyc();
      end
    end
    mwi = 0;
  endtask

  task automatic test_position_major();
    logic eo;
    od = 4'd3; os = SW'(5); mode = 1'b1; out_ready = 1'b1;
    s_init = 1'b1; cyc(); s_init = 1'b0; mwi = 0; cyc();
    for (int p = 0; p < 3; p++) begin
      k_fin = 1'b1; cyc(); k_fin = 1'b0;
      for (int i = 1; i <= 6; i++) begin
        eo = (i >= 3);
        vec++; if (outr !== eo) begin bad++; $display("FAIL pm_outr p=%0d i=%0d got=%0b want=%0b", p, i, outr, eo); end
        if (eo) begin
          vec++;
          if (oa !== AW'(p*4 + i-3)) begin bad++; $display("FAIL pm_oa p=%0d i=%0d got=%0d want=%0d", p, i, oa, p*4 + i-3); end
        end
        vec++; if (done !== 1'b0) begin bad++; $display("FAIL pm_done p=%0d i=%0d got=%0b want=0", p, i, done); end
        cyc();
      end
    end
    mwi = 3;
  endtask

  task automatic test_backpressure();
    logic eo;
    int era, beats;
    mode = 1'b0; cyc();
    beats = 0;
    k_fin = 1'b1; cyc(); k_fin = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      out_ready = !(i >= 4 && i <= 6);
      eo  = (i >= 3 && i <= 9);
      era = (i == 3) ? 0 : (i <= 7) ? 1 : i - 6;
      vec++; if (outr !== eo) begin bad++; $display("FAIL bp_outr i=%0d got=%0b want=%0b", i, outr, eo); end
      if (eo) begin
        vec++;
        if (ra !== CW'(era) || oa !== exp_oa(era, mwi)) begin
          bad++; $display("FAIL bp_addr i=%0d got ra=%0d oa=%0d want ra=%0d oa=%0d", i, ra, oa, era, exp_oa(era, mwi));
        end
      end
      if (outr && out_ready) beats++;
      cyc();
    end
    out_ready = 1'b1;
    vec++; if (beats != 4) begin bad++; $display("FAIL bp_beats got=%0d want=4", beats); end
    mwi = 4;
  endtask

  task automatic test_pending_overflow();
    logic eo;
    int er, ew;
    out_ready = 1'b1;
    k_fin = 1'b1; cyc(); k_fin = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      k_fin = (i == 1 || i == 4);
      eo = (i >= 3 && i <= 6) || (i >= 9 && i <= 12);
      er = (i <= 6) ? i - 3 : i - 9;
      ew = (i <= 6) ? 4 : 0;
      vec++; if (outr !== eo) begin bad++; $display("FAIL po_outr i=%0d got=%0b want=%0b", i, outr, eo); end
      if (eo) begin
        vec++;
        if (ra !== CW'(er) || oa !== exp_oa(er, ew)) begin
          bad++; $display("FAIL po_addr i=%0d got ra=%0d oa=%0d want ra=%0d oa=%0d", i, ra, oa, er, exp_oa(er, ew));
        end
      end
      vec++; if (out_busy !== (i <= 9)) begin bad++; $display("FAIL po_busy i=%0d got=%0b want=%0b", i, out_busy, (i <= 9)); end
      vec++; if (err !== (i >= 5))      begin bad++; $display("FAIL po_err i=%0d got=%0b want=%0b", i, err, (i >= 5)); end
      vec++; if (done !== (i == 7))     begin bad++; $display("FAIL po_done i=%0d got=%0b want=%0b", i, done, (i == 7)); end
      cyc();
    end
    k_fin = 1'b0;
    repeat (3) cyc();
    vec++; if (err !== 1'b1) begin bad++; $display("FAIL po_err_sticky got=%0b want=1", err); end
    mwi = 1;
  endtask

  task automatic test_reset_mid_drain();
    logic eo;
    od = 4'd3; os = SW'(2); mode = 1'b0; out_ready = 1'b1;
    cyc();
    k_fin = 1'b1; cyc(); k_fin = 1'b0;
    repeat (4) cyc();
    vec++; if (outr !== 1'b1 || ra !== CW'(2)) begin bad++; $display("FAIL rmd_pre got outr=%0b ra=%0d want outr=1 ra=2", outr, ra); end
    rst_n = 1'b0;
    #1;
    vec++; if (outr !== 1'b0)     begin bad++; $display("FAIL rmd_outr got=%0b want=0", outr); end
    vec++; if (out_busy !== 1'b0) begin bad++; $display("FAIL rmd_busy got=%0b want=0", out_busy); end
    vec++; if (done !== 1'b0)     begin bad++; $display("FAIL rmd_done got=%0b want=0", done); end
    vec++; if (err !== 1'b0)      begin bad++; $display("FAIL rmd_err got=%0b want=0", err); end
    vec++; if (ra !== '0 || oa !== '0) begin bad++; $display("FAIL rmd_addr got ra=%0d oa=%0d want 0 0", ra, oa); end
    cyc(); rst_n = 1'b1; mwi = 0; cyc();
    k_fin = 1'b1; cyc(); k_fin = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      eo = (i >= 3 && i <= 6);
      vec++; if (outr !== eo) begin bad++; $display("FAIL rmd_re_outr i=%0d got=%0b want=%0b", i, outr, eo); end
      if (eo) begin
        vec++;
        if (ra !== CW'(i-3) || oa !== exp_oa(i-3, 0)) begin
          bad++; $display("FAIL rmd_re_addr i=%0d got ra=%0d oa=%0d want ra=%0d oa=%0d", i, ra, oa, i-3, exp_oa(i-3, 0));
        end
      end
      cyc();
    end
    mwi = 1;
  endtask

  task automatic test_wrap_init();
    logic eo;
    od = '0; os = SW'(1); mode = 1'b0; out_ready = 1'b1;
    s_init = 1'b1; cyc(); s_init = 1'b0; mwi = 0; cyc();
    for (int p = 0; p < 2; p++) begin
      k_fin = 1'b1; cyc(); k_fin = 1'b0;
      for (int i = 1; i <= 5; i++) begin
        s_init = (p == 0 && i == 3);
        eo = (i == 3);
        vec++; if (outr !== eo) begin bad++; $display("FAIL wr_outr p=%0d i=%0d got=%0b want=%0b", p, i, outr, eo); end
        if (eo) begin
          vec++; if (ra !== '0 || oa !== '0) begin bad++; $display("FAIL wr_addr p=%0d got ra=%0d oa=%0d want 0 0", p, ra, oa); end
        end
        vec++; if (done !== (i == 4)) begin bad++; $display("FAIL wr_done p=%0d i=%0d got=%0b want=%0b", p, i, done, (i == 4)); end
        cyc();
      end
      s_init = 1'b0;
    end
    mwi = 0;
  endtask

  task automatic test_random();
    int c, guard;
    logic sd, cond, edone;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        od = CW'($urandom_range(0, 15));
        os = SW'($urandom_range(1, 6));
        mode = 1'($urandom_range(0, 1));
        s_init = 1'b1; cyc(); s_init = 1'b0; mwi = 0;
      end
      k_fin = 1'b1; cyc(); k_fin = 1'b0;
      for (int i = 1; i <= int'(LAT); i++) begin
        vec++; if (outr !== 1'b0 || out_busy !== 1'b1) begin
          bad++; $display("FAIL rnd_wait n=%0d i=%0d got outr=%0b busy=%0b want 0 1", n, i, outr, out_busy);
        end
        cyc();
      end
      c = 0; guard = 0; sd = 1'b0; cond = 1'b1;
      while (c <= int'(od) && guard < 400) begin
        out_ready = ($urandom_range(0, 3) != 0);
        s_init = ($urandom_range(0, 15) == 0);
        if (s_init) sd = 1'b1;
        vec++; if (outr !== 1'b1) begin bad++; $display("FAIL rnd_outr n=%0d c=%0d got=%0b want=1", n, c, outr); end
        vec++; if (ra !== CW'(c) || oa !== exp_oa(c, mwi)) begin
          bad++; $display("FAIL rnd_addr n=%0d got ra=%0d oa=%0d want ra=%0d oa=%0d", n, ra, oa, c, exp_oa(c, mwi));
        end
        vec++; if (out_busy !== cond) begin bad++; $display("FAIL rnd_busy n=%0d c=%0d got=%0b want=%0b", n, c, out_busy, cond); end
        cond = (c + int'(BL) < int'(od));
        if (out_ready) c++;
        guard++;
        cyc();
      end
      s_init = 1'b0;
      if (guard >= 400) begin
        vec++; bad++; $display("FAIL rnd_timeout n=%0d got c=%0d want %0d", n, c, int'(od) + 1);
      end
      edone = (mwi == int'(os) - 1);
      vec++; if (outr !== 1'b0) begin bad++; $display("FAIL rnd_end_outr n=%0d got=%0b want=0", n, outr); end
      vec++; if (done !== edone) begin bad++; $display("FAIL rnd_done n=%0d got=%0b want=%0b", n, done, edone); end
      vec++; if (out_busy !== 1'b0) begin bad++; $display("FAIL rnd_end_busy n=%0d got=%0b want=0", n, out_busy); end
      mwi = sd ? 0 : (edone ? 0 : mwi + 1);
    end
  endtask

  initial begin
    test_reset();
    test_channel_major();
    test_position_major();
    test_backpressure();
    test_pending_overflow();
    test_reset_mid_drain();
    test_wrap_init();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/out_ctrl_p.md
# out_ctrl_p

Parametrised output write-back sequencer. It sits between the convolution/FC accumulator array and the output buffer. After each kernel-finish pulse, it walks the output channels and emits one read index (`ra`) and one buffer address (`oa`) per channel. Compared with the fixed-width out_ctrl it adds:
- generic widths and a configurable kernel-finish latency;
- a downstream ready/valid handshake;
- a one-deep pending-finish buffer;
- a position-major address mode;
- end-of-sample and overflow status.

## Interface
- `CW`, 4: channel index width; channel count is `od+1`, max 2^CW.
- `SW`, 10: spatial position width (`os`, `wi`).
- `AW`, 12: output address width.
- `LAT`, 2: cycles from `k_fin` until accumulator results are readable; legal range 1..15.
- `BUSY_LEAD`, 3: channels before the end of a drain at which `out_busy` drops.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `s_init`  in  1  pulse: new sample; position counter returns to 0.
- `k_fin`  in  1  pulse: accumulators hold results for the current position.
- `od`  in  CW  last channel index; static while not IDLE.
- `os`  in  SW  positions per channel (≥1); static while not IDLE.
- `mode`  in  1  0 = channel-major `oa=ct*os+wi`; 1 = position-major `oa=wi*(od+1)+ct`.
- `out_ready`  in  1  downstream accepts the current beat.
- `outr`  out  1  beat valid.
- `ra`  out  CW  accumulator channel to read (= ct).
- `oa`  out  AW  output buffer address.
- `out_busy`  out  1  accumulators not yet free for the next kernel pass.
- `done`  out  1  one-cycle pulse: last position of the sample written.
- `err`  out  1  sticky: `k_fin` lost. Cleared only by reset.

## Operation
**States:** IDLE, WAIT, DRAIN.

**Counters and flags:**
- `lc` (4 bit): latency count.
- `ct` (CW): channel.
- `wi` (SW): position.
- `pend` (1): buffered `k_fin`.
- `sinit_d` (1): deferred `s_init`.

**Transitions:**
- IDLE + `k_fin`: go to WAIT with `lc=LAT-1`.
- WAIT: decrement `lc`. When `lc==0`, go to DRAIN with `ct=0`.
- DRAIN: `outr=1`. A beat is accepted when `outr&out_ready`, which advances `ct`. With `out_ready=0`, `ct`, `ra` and `oa` hold.
- Beat accepted at `ct==od` (end of drain):
  - If `wi==os-1`: set `wi=0` and pulse `done` next cycle.
  - Otherwise: `wi=wi+1`.
  - Then, if `pend`: clear `pend`, go to WAIT with `lc=LAT-1`. Otherwise go to IDLE.

**`k_fin` outside IDLE:**
- If `pend=0`: set `pend`.
- If `pend=1` (or `pend` is being consumed that same cycle): set `err`; the pulse is dropped.

**`s_init`:**
- In IDLE: `wi=0` next cycle.
- Otherwise: set `sinit_d`. At end of drain, `wi=0` is applied after, and overriding, the increment; no `done` is generated by `s_init`.
- `s_init` and `k_fin` together in IDLE: `wi=0`, then start WAIT.

**`out_busy`:**
- Set by `k_fin`.
- Stays 1 through WAIT, and through DRAIN while `ct+BUSY_LEAD < od` (compare at CW+2 bits).
- Otherwise 0.
- Forced 1 while `pend=1`.

**Arithmetic:**
- Products are computed at CW+SW bits.
- Sums are truncated to AW; no saturation.
- `od+1` is computed at CW+1 bits.

**Reset (rst_n=0):**
- State IDLE.
- `lc`, `ct`, `wi`, `pend`, `sinit_d`, `err` = 0.
- Outputs: `outr`=0, `out_busy`=0, `done`=0, `err`=0, `ra`=0, `oa`=0.
- Reset mid-drain abandons the drain immediately; no beat is completed.

## Timing
- `k_fin` in cycle T (IDLE): `outr` is first high in cycle T+LAT+1, with `ra=0`. With LAT=2 this is T+3.
- With `out_ready` held 1: one beat per cycle. `outr` falls in the cycle after the `ct==od` beat.
- Pending `k_fin`: after the last beat, WAIT restarts. Next `outr` is LAT+1 cycles after that beat.
- `done`: registered, in the cycle after the final beat of the sample.
- `ra`/`oa`: combinational from registered `ct`/`wi`/`mode`. Stable while `outr&!out_ready`.
- `out_busy`: registered, updates the cycle after the condition changes.

## Structure
- Package `tiny_dnn_pkg`:
  - state enum `oc_state_t` {IDLE, WAIT, DRAIN};
  - default widths `CH_W`=4, `SP_W`=10, `AD_W`=12.
- One sub-module: `loop1`, the generic init/fin/start/next counter, instantiated for `ct` and `wi`.
- State machine, `pend`, address mux and busy logic stay in the top.

## Test plan
1. Reset mid-drain:
   - Stimulus: `od=3`, `os=2`, LAT=2, `out_ready=1`, `rst_n` pulsed low at ct=2.
   - Required: all outputs 0 asynchronously; next `k_fin` restarts at `ra=0`, `oa=0`.
2. Channel-major, two positions:
   - Stimulus: `od=3`, `os=2`, `mode=0`, `s_init`, then `k_fin` at T.
   - Required: beats at T+3..T+6 with `oa`=0,2,4,6. Second `k_fin`: `oa`=1,3,5,7, `done` one cycle after the last beat.
   - Also check: `out_busy` falls the cycle after the ct=0 beat (ct+3<3 false).
3. Position-major:
   - Stimulus: `od=3`, `os=5`, `mode=1`, third `k_fin` (wi=2).
   - Required: `oa`=8,9,10,11.
4. Backpressure:
   - Stimulus: `out_ready` low in cycles T+4..T+6.
   - Required: `ra=1`/`oa` held stable for three cycles with `outr=1`; four beats total; no duplicate or skipped `ra`.
5. Pending and overflow:
   - Stimulus: second `k_fin` during WAIT, then third `k_fin` during DRAIN.
   - Required: the second pass starts LAT+1 cycles after the first pass's last beat; `err=1` after the third and stays 1.
6. Wrap and deferred init:
   - Stimulus: `os=1`, `od=0`; `s_init` during DRAIN.
   - Required: single beat `oa=0`, `done` pulse, `wi` stays 0; the next pass also gives `oa=0`.
